// File: rtl/keypad_code_fifo.sv
// keypad_code_fifo
//
// Consumer end of the keypad scanner interface. Each key_valid strobe
// carries a 6-bit scan code {column index[1:0], row lines[3:0]} with the
// row lines active-low. A code with exactly one row line low is translated
// to a 4-bit key value and queued in a show-ahead FIFO. Any other row
// pattern is rejected and flagged.
//
// Optional feature, enabled by defining KEYPAD_REPEAT_FILTER_EN:
//   A valid code equal to the last accepted code, arriving within HOLDOFF
//   cycles of that acceptance, is discarded without any flag.
//
// Parameters:
//   DEPTH    FIFO entries (power of two, 2..64)
//   AW       pointer width, log2(DEPTH)
//   HOLDOFF  repeat-filter window in clk cycles (filter build only)
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   key_code  scan code: [5:4] column index, [3:0] row lines (active-low)
//   key_valid one-cycle strobe qualifying key_code
//   rd_en     pop the head entry at this clock edge
//   dout      head key value (holds last popped value while empty)
//   empty     FIFO holds no entries
//   full      FIFO holds DEPTH entries
//   level     current entry count
//   overflow  sticky: a valid key was dropped because the FIFO was full
//   bad_code  one-cycle pulse after a strobe with an invalid row pattern
//   bad_cnt   saturating count of invalid codes

module keypad_code_fifo #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int HOLDOFF = 1000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [5:0]    key_code,
    input  logic          key_valid,
    input  logic          rd_en,
    output logic [3:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic          bad_code,
    output logic [7:0]    bad_cnt
);

    // Reject parameter combinations the pointer arithmetic cannot support.
    if (DEPTH != (1 << AW) || AW < 1 || AW > 6 || HOLDOFF < 1) begin : g_param_check
        $error("keypad_code_fifo: DEPTH must equal 2**AW (2..64) and HOLDOFF must be >= 1");
    end

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [3:0]    last_pop;

    logic          row_ok;
    logic [1:0]    row_idx;
    logic [3:0]    key_val;
    logic          repeat_hit;
    logic          push_req;
    logic          do_push;
    logic          do_pop;

    // Row decode: exactly one active-low row line identifies the row.
    always_comb begin
        row_ok  = 1'b1;
        row_idx = 2'd0;
        case (key_code[3:0])
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: row_ok  = 1'b0;
        endcase
    end

    // Key value lookup; index = row*4 + column, so it is just {row, column}.
    // '*' is encoded as E and '#' as F.
    always_comb begin
        key_val = 4'h0;
        case ({row_idx, key_code[5:4]})
            4'd0:    key_val = 4'h1;
            4'd1:    key_val = 4'h2;
            4'd2:    key_val = 4'h3;
            4'd3:    key_val = 4'hA;
            4'd4:    key_val = 4'h4;
            4'd5:    key_val = 4'h5;
            4'd6:    key_val = 4'h6;
            4'd7:    key_val = 4'hB;
            4'd8:    key_val = 4'h7;
            4'd9:    key_val = 4'h8;
            4'd10:   key_val = 4'h9;
            4'd11:   key_val = 4'hC;
            4'd12:   key_val = 4'hE;
            4'd13:   key_val = 4'h0;
            4'd14:   key_val = 4'hF;
            default: key_val = 4'hD;
        endcase
    end

`ifdef KEYPAD_REPEAT_FILTER_EN
    logic [5:0]  last_code;
    logic        last_code_ok;
    logic [31:0] hold_cnt;

    // A repeat is only suppressed while the holdoff window is still open.
    assign repeat_hit = last_code_ok && (key_code == last_code) && (hold_cnt != 32'd0);

    // Remember the last code that actually landed in the FIFO and restart
    // the holdoff window from that push.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_code    <= 6'd0;
            last_code_ok <= 1'b0;
            hold_cnt     <= 32'd0;
        end else if (do_push) begin
            last_code    <= key_code;
            last_code_ok <= 1'b1;
            hold_cnt     <= 32'(HOLDOFF);
        end else if (hold_cnt != 32'd0) begin
            hold_cnt     <= hold_cnt - 32'd1;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    // A full FIFO can still accept a push when the same edge pops the head.
    assign push_req = key_valid && row_ok && !repeat_hit;
    assign do_pop   = rd_en && !empty;
    assign do_push  = push_req && (!full || do_pop);

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    // When empty, rd_ptr points at a stale slot, so show the last popped
    // value instead.
    assign dout = empty ? last_pop : mem[rd_ptr];

    // FIFO storage, pointers and entry count.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 4'h0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_pop <= 4'h0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= key_val;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                last_pop <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Status flags: sticky overflow, invalid-code pulse and saturating count.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
            bad_cnt  <= 8'd0;
        end else begin
            if (push_req && full && !do_pop) begin
                overflow <= 1'b1;
            end
            bad_code <= key_valid && !row_ok;
            if (key_valid && !row_ok && bad_cnt != 8'hFF) begin
                bad_cnt <= bad_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/keypad_code_fifo.md
Name: keypad_code_fifo

Overview:
- Consumer end of the keypad scanner interface. Takes the 6-bit scan code {column index[1:0], row[3:0]} and its one-cycle data-enable strobe.
- Validates the row pattern, translates the code to a 4-bit key value, and queues values in a show-ahead FIFO for a downstream reader (display or entry logic).
- Runs on the same clock as the scanner.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64
- AW, 3, pointer width; must equal log2(DEPTH)
- HOLDOFF, 1000, repeat-filter window in clk cycles (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- key_code  input  6  scan code: [5:4] column index c, [3:0] row lines, active-low
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle
- rd_en  input  1  pop head entry at this clock edge
- dout  output  4  head key value; valid while empty=0
- empty  output  1  FIFO holds 0 entries
- full  output  1  FIFO holds DEPTH entries
- level  output  AW+1  current entry count
- overflow  output  1  sticky; a valid key was dropped because the FIFO was full
- bad_code  output  1  one-cycle pulse; strobed code had an invalid row pattern
- bad_cnt  output  8  saturating count of invalid codes

Behaviour:
- Reset: all registers clear while rst=1. After reset: dout=0, empty=1, full=0, level=0, overflow=0, bad_code=0, bad_cnt=0, pointers=0. Reset dominates all other inputs, including mid-push or mid-pop.
- Row decode:
  - 1110→r=0, 1101→r=1, 1011→r=2, 0111→r=3.
  - Any other pattern (0 or ≥2 rows low) is invalid.
- Key index idx = r*4 + c. Value table, idx 0..15: 1,2,3,A,4,5,6,B,7,8,9,C,E,0,F,D. (* maps to E, # maps to F.)
- Push: key_valid=1 with a valid code writes the value at wr_ptr at the clock edge.
  - level, empty and full update at that same edge, so empty drops the cycle after the strobe.
- Invalid code: nothing is written. bad_code=1 for exactly the next cycle. bad_cnt increments and sticks at 255.
- key_valid=0: key_code is ignored.
- Pop:
  - rd_en=1 with empty=0 advances rd_ptr and decrements level.
  - rd_en=1 with empty=1 is ignored; no underflow and no state change.
- dout is a combinational read of mem[rd_ptr] (show-ahead). dout holds its last value when empty.
- Push with pop while full: both occur, level stays DEPTH, no overflow.
- Push with pop while empty: push occurs, pop ignored, level becomes 1.
- Push while full with no pop: value dropped; overflow set and held until rst.
- Pointers wrap modulo DEPTH. full ⇔ level==DEPTH. empty ⇔ level==0.

Optional Feature:
- Macro KEYPAD_REPEAT_FILTER_EN.
- Defined:
  - A valid code equal to the last accepted code, arriving within HOLDOFF cycles of that acceptance, is discarded.
  - Discarded codes are not pushed and do not flag overflow or bad_code.
  - Holdoff counter: 32 bits, reloaded on each accepted push, saturates at 0.
  - A different code is accepted immediately.
  - Reset clears the last-code register to "none", so the first key is always accepted.
- Not defined: every valid code is pushed. No holdoff counter or last-code register is synthesized.

Test Plan:
- Reset, then strobe key_code=6'b00_1110 → next cycle empty=0, level=1, dout=4'h1. Then rd_en=1 one cycle → empty=1, level=0.
- Strobe codes 01_1101, 10_0111, 11_1011 → dout sequence 4'h5, 4'hF, 4'hC, popped in that order.
- Strobe key_code=6'b00_1100 → bad_code=1 for one cycle, bad_cnt=1, level unchanged. Send 300 invalid strobes → bad_cnt=255.
- Fill 8 entries, then strobe 00_0111 with rd_en=0 → overflow=1, level=8, head unchanged. Repeat with rd_en=1 → level stays 8, overflow unchanged, new value becomes the tail.
- Strobe while empty with rd_en=1 → level=1. Assert rst mid-burst → all outputs at reset values the next cycle.
- With KEYPAD_REPEAT_FILTER_EN and HOLDOFF=10:
  - 00_1110 twice, 5 cycles apart → level=1.
  - Same code again 12 cycles later → level=2.
  - 01_1110 right after → accepted.
